muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO architectural registers.
- Sits beside the EX-stage ALU and sequences MULT/DIV (ALU control 1111/1110), one radix-2 step per cycle.
- Serves MFHI/MFLO reads (ALU control 1010/1011).
- Raises a stall request that the top level ORs into AnyStall while a result is not yet available.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- Start_EX  input  1  request a new operation this cycle.
- IsDiv_EX  input  1  0 = MULT, 1 = DIV; sampled with Start_EX.
- SrcA_EX  input  WIDTH  rs operand (multiplicand / dividend), two's complement.
- SrcB_EX  input  WIDTH  rt operand (multiplier / divisor), two's complement.
- RdHi_EX  input  1  MFHI in EX.
- RdLo_EX  input  1  MFLO in EX.
- Kill  input  1  pipeline flush; aborts any in-flight operation.
- MdStall  output  1  stall request to the hazard logic.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse when HI/LO update.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

Behaviour:
- Clock is clk. Reset is synchronous, active-high, named reset.
- Reset state: state = IDLE, Hi = 0, Lo = 0, Busy = 0, Done = 0, MdStall = 0, counter = 0.
- States: IDLE, MUL, DIV, FIX, DZ.
- IDLE:
  - Start_EX=1 latches the magnitudes |SrcA| and |SrcB| and the result signs.
  - Result sign: product sign = a31^b31; quotient sign = a31^b31; remainder sign = a31.
  - Counter loads WIDTH.
  - Next state: MUL if IsDiv_EX=0; DIV if IsDiv_EX=1 and SrcB≠0; DZ if IsDiv_EX=1 and SrcB=0.
- MUL: one shift-add step per cycle on a 2·WIDTH accumulator. Counter decrements; go to FIX when the counter reaches 1.
- DIV: one restoring shift-subtract step per cycle. Quotient bit = 1 when the trial remainder ≥ 0. Go to FIX when the counter reaches 1.
- FIX: apply two's-complement sign correction, then write the result:
  - MULT: Hi = product[2W-1:W], Lo = product[W-1:0].
  - DIV: Lo = quotient, Hi = remainder.
  - Assert Done for this cycle only; return to IDLE.
- DZ: write Hi = SrcA as latched (original sign), Lo = all ones; pulse Done; return to IDLE. Total 2 cycles.
- Latency: Start accepted in cycle 0; HI/LO visible from cycle WIDTH+1, i.e. 33 cycles for WIDTH=32.
- Signed overflow: -2^31 / -1 gives Lo = 0x80000000, Hi = 0. This falls out of the magnitude algorithm; no special case.
- Busy = (state ≠ IDLE).
- MdStall = Busy & (RdHi_EX | RdLo_EX | Start_EX). This is combinational from the registered state and the EX inputs.
  - Start_EX while Busy is not accepted; it is re-presented by the stalled pipeline.
  - A read, or a start, arriving in the FIX cycle still stalls. It proceeds the next cycle and sees the new HI/LO.
- Hi and Lo are unchanged except at FIX/DZ completion or reset. Reads in IDLE return the current registers with no stall.
- Kill: in any non-IDLE state, the next state is IDLE, HI/LO are unchanged, and no Done pulse is produced.
- Kill with Start_EX in the same cycle: Kill wins; the start is dropped.
- reset has priority over Kill and Start_EX.
- No timing path from MdStall back into Start_EX acceptance: acceptance depends only on the state.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in MUL, if the remaining unshifted multiplier bits are all zero, jump straight to FIX by shifting the accumulator by the remaining count in a single cycle.
  - Result: MULT latency = 2 + index of the highest set bit of |SrcB|.
  - |SrcB| = 0 completes in 2 cycles.
  - DIV timing is unchanged.
- Undefined: MULT always takes WIDTH+1 cycles. Results are bit-identical either way.

Test Plan:
- MULT 7 × -3 (SrcA=0x00000007, SrcB=0xFFFFFFFD) → Done at cycle 33; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. MdStall=1 for a concurrent RdLo_EX until Done+1.
- DIV -7 / 2 → Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0.
- DIV 5 / 0 → Done in the cycle after Start; Hi=5, Lo=0xFFFFFFFF; Busy for exactly 1 cycle after Start.
- MULT 0x12345678 × 0x10 started, Kill at cycle 10 → state IDLE, no Done, Hi/Lo keep their prior values. A new Start in the same cycle as Kill is ignored.
- Back-to-back: second Start_EX held from cycle 1 → MdStall=1 until the FIX cycle; the second op is accepted the cycle after Done, and its result overwrites the first.
- With MULDIV_EARLY_OUT_EN: MULT 0xFFFFFFFF × 3 → Done at cycle 3; Hi=0xFFFFFFFF, Lo=0xFFFFFFFD (-3). Without the macro, the same result at cycle 33.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 MULT/DIV sequencer owning the HI/LO registers.
// Signed operands are handled as magnitudes plus latched result signs; the
// sign correction is applied in the FIX state just before HI/LO are written.
// Optional build macro: MULDIV_EARLY_OUT_EN (MULT finishes as soon as the
// remaining multiplier bits are all zero; results are identical either way).
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start_EX,
    input  logic             IsDiv_EX,
    input  logic [WIDTH-1:0] SrcA_EX,
    input  logic [WIDTH-1:0] SrcB_EX,
    input  logic             RdHi_EX,
    input  logic             RdLo_EX,
    input  logic             Kill,
    output logic             MdStall,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DZ} state_t;

    state_t               r_state;
    logic [CNTW-1:0]      r_cnt;
    logic [2*WIDTH-1:0]   r_acc;      // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0]     r_opnd;     // MUL: |multiplicand|; DIV: |divisor|
    logic                 r_isdiv;
    logic                 r_sign_q;   // sign of product / quotient
    logic                 r_sign_r;   // sign of remainder (and of SrcA for divide-by-zero)
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_madd;
    logic [2*WIDTH-1:0]   w_mstep;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_dtrial;
    logic [2*WIDTH-1:0]   w_dstep;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_dzhi;
`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [WIDTH-1:0] ONES = '1;
    logic                 w_early;
    logic [2*WIDTH-1:0]   w_mshift;
`endif

    // Operand magnitudes, one shift-add / shift-subtract step, and sign-corrected results
    always_comb begin
        w_abs_a  = SrcA_EX[WIDTH-1] ? -SrcA_EX : SrcA_EX;
        w_abs_b  = SrcB_EX[WIDTH-1] ? -SrcB_EX : SrcB_EX;

        w_madd   = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        if (r_acc[0]) begin
            w_madd = w_madd + {1'b0, r_opnd};
        end
        w_mstep  = {w_madd, r_acc[WIDTH-1:1]};

        // The shifted remainder is WIDTH+1 bits; when it is >= divisor the
        // difference is below the divisor, so WIDTH bits of it suffice.
        w_ge     = (r_acc[2*WIDTH-1:WIDTH-1] >= {1'b0, r_opnd});
        w_dtrial = r_acc[2*WIDTH-2:WIDTH-1] - r_opnd;
        w_dstep  = {(w_ge ? w_dtrial : r_acc[2*WIDTH-2:WIDTH-1]), r_acc[WIDTH-2:0], w_ge};

        w_prod   = r_sign_q ? -r_acc : r_acc;
        w_quo    = r_sign_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem    = r_sign_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_dzhi   = r_sign_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
`ifdef MULDIV_EARLY_OUT_EN
        // Multiplier bits still to be consumed after this step are [r_cnt-1:1];
        // if none are set, the remaining steps are pure shifts.
        w_early  = (((r_acc[WIDTH-1:0] & ~(ONES << r_cnt)) >> 1) == '0);
        w_mshift = w_mstep >> (r_cnt - CNTW'(1));
`endif
    end

    assign Busy    = (r_state != IDLE);
    assign MdStall = Busy & (RdHi_EX | RdLo_EX | Start_EX);
    assign Done    = r_done & ~Kill;
    assign Hi      = r_hi;
    assign Lo      = r_lo;

    // Sequencer FSM: accept in IDLE, iterate, then correct signs and write HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_isdiv  <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (Kill) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (Start_EX) begin
                            r_isdiv  <= IsDiv_EX;
                            r_sign_q <= SrcA_EX[WIDTH-1] ^ SrcB_EX[WIDTH-1];
                            r_sign_r <= SrcA_EX[WIDTH-1];
                            r_cnt    <= CNTW'(WIDTH);
                            if (IsDiv_EX) begin
                                r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                                r_opnd <= w_abs_b;
                                if (SrcB_EX == '0) begin
                                    r_state <= DZ;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= DIV;
                                end
                            end else begin
                                r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
                                r_opnd  <= w_abs_a;
                                r_state <= MUL;
                            end
                        end
                    end
                    MUL: begin
                        r_cnt <= r_cnt - CNTW'(1);
`ifdef MULDIV_EARLY_OUT_EN
                        if (r_cnt == CNTW'(1) || w_early) begin
                            r_acc   <= w_mshift;
                            r_state <= FIX;
                            r_done  <= 1'b1;
                        end else begin
                            r_acc   <= w_mstep;
                        end
`else
                        r_acc <= w_mstep;
                        if (r_cnt == CNTW'(1)) begin
                            r_state <= FIX;
                            r_done  <= 1'b1;
                        end
`endif
                    end
                    DIV: begin
                        r_cnt <= r_cnt - CNTW'(1);
                        r_acc <= w_dstep;
                        if (r_cnt == CNTW'(1)) begin
                            r_state <= FIX;
                            r_done  <= 1'b1;
                        end
                    end
                    FIX: begin
                        if (r_isdiv) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                        r_state <= IDLE;
                    end
                    DZ: begin
                        r_hi    <= w_dzhi;
                        r_lo    <= '1;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
